// File: rtl/cpu_datapath_if.sv
// cpu_datapath_if: external memory bus between the datapath and memory
interface cpu_datapath_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/cpu_datapath.sv
// cpu_datapath: 8-bit register/bus datapath driven by the control unit's per-cycle control word
module cpu_datapath (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            in_sel,
  input  logic [2:0]            out_sel,
  input  logic                  pcc,
  input  logic                  iri,
  input  logic [7:0]            alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  cpu_datapath_if.master        mem,
  output logic [7:0]            reg_a,
  output logic [7:0]            reg_b,
  output logic [7:0]            bus,
  output logic [7:0]            ir_data,
  output logic [7:0]            out_port,
  output logic                  out_valid,
  output logic [15:0]           pc
);
  logic [7:0]  reg_c, reg_d, stage;
  logic [15:0] mar;
  logic        flag_c, flag_z, taken;
  // bus source mux
  always_comb begin
    bus = 8'h00;
    case (out_sel)
      3'd1: bus = reg_a;
      3'd2: bus = reg_b;
      3'd3: bus = reg_c;
      3'd4: bus = reg_d;
      3'd5: bus = alu_result;
      3'd6: bus = mem.mem_rdata;
      3'd7: bus = pc[7:0];
      default: bus = 8'h00;
    endcase
  end
  assign taken = (in_sel == 4'd10) | (in_sel == 4'd11 & flag_z) |
                 (in_sel == 4'd12 & flag_c) | (in_sel == 4'd13 & ~flag_z);
  assign mem.mem_addr  = iri ? pc : mar;
  assign mem.mem_wdata = bus;
  assign mem.mem_we    = in_sel == 4'd7;
  assign ir_data       = mem.mem_rdata;
  // sink loads, PC sequencing and flag capture; conditions use the flags held before this edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_a     <= '0;
      reg_b     <= '0;
      reg_c     <= '0;
      reg_d     <= '0;
      mar       <= '0;
      stage     <= '0;
      pc        <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      out_port  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (in_sel)
        4'd1: reg_a <= bus;
        4'd2: reg_b <= bus;
        4'd3: reg_c <= bus;
        4'd4: reg_d <= bus;
        4'd5: mar[7:0] <= bus;
        4'd6: mar[15:8] <= bus;
        4'd8: out_port <= bus;
        4'd9: stage <= bus;
        default: ;
      endcase
      pc        <= taken ? {bus, stage} : pcc ? pc + 16'd1 : pc;
      out_valid <= in_sel == 4'd8;
      if (out_sel == 3'd5) begin
        flag_c <= alu_carry;
        flag_z <= alu_zero;
      end
    end
  end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: randomized and directed check of cpu_datapath against a behavioural model
module tb_cpu_datapath;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in_sel = '0;
  logic [2:0]  out_sel = '0;
  logic        pcc = 1'b0, iri = 1'b0;
  logic [7:0]  alu_result = '0;
  logic        alu_carry = 1'b0, alu_zero = 1'b0;
  logic [7:0]  reg_a, reg_b, bus, ir_data, out_port;
  logic        out_valid;
  logic [15:0] pc;
  int vectors = 0, miscompares = 0;
  cpu_datapath_if mif();
  cpu_datapath dut (
    .clk(clk), .reset(reset), .in_sel(in_sel), .out_sel(out_sel), .pcc(pcc), .iri(iri),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero), .mem(mif.master),
    .reg_a(reg_a), .reg_b(reg_b), .bus(bus), .ir_data(ir_data), .out_port(out_port),
    .out_valid(out_valid), .pc(pc)
  );
  always #5 clk = ~clk;
  // behavioural model: regs[1..4] are A..D
  logic [7:0]  regs [8];
  logic [15:0] m_mar, m_pc;
  logic [7:0]  m_stage, m_out;
  logic        m_c, m_z, m_ov;
  function automatic logic [7:0] m_bus();
    if (out_sel >= 3'd1 && out_sel <= 3'd4) return regs[out_sel];
    if (out_sel == 3'd5) return alu_result;
    if (out_sel == 3'd6) return mif.mem_rdata;
    if (out_sel == 3'd7) return m_pc[7:0];
    return 8'h00;
  endfunction
  always @(posedge clk or posedge reset) begin
    logic [7:0] b;
    logic jump;
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] = 8'h00;
      m_mar = 0; m_pc = 0; m_stage = 0; m_out = 0; m_c = 0; m_z = 0; m_ov = 0;
    end else begin
      b = m_bus();
      jump = in_sel == 10 || (in_sel == 11 && m_z) || (in_sel == 12 && m_c) || (in_sel == 13 && !m_z);
      if (in_sel >= 1 && in_sel <= 4) regs[in_sel] = b;
      if (in_sel == 5) m_mar = {m_mar[15:8], b};
      if (in_sel == 6) m_mar = {b, m_mar[7:0]};
      if (in_sel == 8) m_out = b;
      if (in_sel == 9) m_stage = b;
      if (jump) m_pc = {b, m_stage};
      else if (pcc) m_pc = m_pc + 1;
      if (out_sel == 5) begin m_c = alu_carry; m_z = alu_zero; end
      m_ov = in_sel == 8;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // compare process: every cycle out of reset, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      chk("bus", bus, m_bus());
      chk("mem_addr", mif.mem_addr, iri ? m_pc : m_mar);
      chk("mem_we", mif.mem_we, in_sel == 7);
      chk("mem_wdata", mif.mem_wdata, m_bus());
      chk("ir_data", ir_data, mif.mem_rdata);
      chk("reg_a", reg_a, regs[1]);
      chk("reg_b", reg_b, regs[2]);
      chk("pc", pc, m_pc);
      chk("out_port", out_port, m_out);
      chk("out_valid", out_valid, m_ov);
    end
  end
  task automatic set(input logic [3:0] i, input logic [2:0] o, input logic p, input logic f, input logic [7:0] rd);
    in_sel = i; out_sel = o; pcc = p; iri = f; mif.mem_rdata = rd;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    mif.mem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("reset_pc", pc, 16'h0000);
    chk("reset_bus", bus, 8'h00);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_a", reg_a, 8'h00);
    set(0, 0, 1, 1, 8'h5A);
    repeat (3) tick();
    chk("fetch_pc", pc, 16'h0003);
    chk("fetch_addr", mif.mem_addr, 16'h0003);
    chk("fetch_ir", ir_data, 8'h5A);
    set(1, 6, 0, 0, 8'h3C); tick();
    chk("xfer_a", reg_a, 8'h3C);
    set(3, 1, 0, 0, 8'h00); tick();
    set(8, 3, 0, 0, 8'h00); tick();
    chk("xfer_out", out_port, 8'h3C);
    chk("xfer_valid", out_valid, 1'b1);
    set(0, 0, 0, 0, 8'h00); tick();
    chk("xfer_valid_drop", out_valid, 1'b0);
    set(9, 6, 0, 0, 8'h34); tick();
    set(10, 6, 1, 0, 8'h12); tick();
    chk("jmp_pc", pc, 16'h1234);
    set(11, 6, 1, 0, 8'h99); tick();
    chk("jz_not_taken", pc, 16'h1235);
    alu_zero = 1'b1;
    set(0, 5, 0, 0, 8'h00); tick();
    alu_zero = 1'b0;
    set(11, 6, 0, 0, 8'h40); tick();
    chk("jz_taken", pc, 16'h4034);
    set(9, 6, 0, 0, 8'hFF); tick();
    set(10, 6, 0, 0, 8'hFF); tick();
    chk("pc_ffff", pc, 16'hFFFF);
    set(0, 0, 1, 0, 8'h00); tick();
    chk("pc_wrap", pc, 16'h0000);
    set(5, 6, 0, 0, 8'hCD); tick();
    set(6, 6, 0, 0, 8'hAB); tick();
    set(2, 6, 0, 0, 8'h77); tick();
    set(7, 2, 0, 0, 8'h00); #1;
    chk("wr_addr", mif.mem_addr, 16'hABCD);
    chk("wr_we", mif.mem_we, 1'b1);
    chk("wr_data", mif.mem_wdata, 8'h77);
    tick();
    set(9, 6, 1, 0, 8'h55); tick();
    set(10, 6, 1, 0, 8'h66); #3;
    reset = 1'b1;
    #1 chk("midreset_pc", pc, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    set(10, 0, 0, 0, 8'h00); tick();
    chk("post_reset_jmp", pc, 16'h0000);
    repeat (2000) begin
      set($urandom_range(15), $urandom_range(7), $urandom_range(1), $urandom_range(1), $urandom_range(255));
      alu_result = $urandom_range(255);
      alu_carry = $urandom_range(1);
      alu_zero = $urandom_range(1);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
